// File: rtl/cpu_mem_responder.sv
// Memory-side responder: turns sequencer fetch/load/store strobes into single BRAM
// transactions, with a one-entry pending slot and a small MMIO window for the Pong I/O.
module cpu_mem_responder #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 10'h3F0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out
);

  typedef enum logic [1:0] {StIdle, StRdWait, StRdData, StWr} state_e;
  // Encoding matches the bit positions of req_rise.
  typedef enum logic [1:0] {ReqFetch, ReqLoad, ReqStore} req_e;

  state_e            state_q, state_d;
  logic [2:0]        req_prev_q, req_rise;
  logic              pend_valid_q, pend_valid_d;
  req_e              pend_type_q, pend_type_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
  req_e              cur_type_q, cur_type_d;
  logic              cur_mmio_q, cur_mmio_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;
  logic              bram_we_q, bram_we_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  logic              issue_v, issue_mmio, slot_free;
  req_e              issue_type;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  assign req_rise = {store_req, load_req, fetch_req} & ~req_prev_q;

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_type_d   = pend_type_q;
    pend_addr_d   = pend_addr_q;
    pend_wdata_d  = pend_wdata_q;
    cur_type_d    = cur_type_q;
    cur_mmio_d    = cur_mmio_q;
    bram_addr_d   = bram_addr_q;
    bram_din_d    = bram_din_q;
    bram_we_d     = 1'b0;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    load_data_d   = load_data_q;
    load_valid_d  = 1'b0;
    io_out_d      = io_out_q;
    overrun_d     = overrun_q;
    sync1_d       = io_in;
    sync2_d       = sync1_q;
    issue_v       = 1'b0;
    issue_type    = ReqFetch;
    issue_addr    = cpu_addr;
    issue_wdata   = cpu_wdata;
    slot_free     = !pend_valid_q;

    // A waiting entry always goes ahead of anything arriving this cycle.
    if (state_q == StIdle && pend_valid_q) begin
      issue_v      = 1'b1;
      issue_type   = pend_type_q;
      issue_addr   = pend_addr_q;
      issue_wdata  = pend_wdata_q;
      slot_free    = 1'b1;
      pend_valid_d = 1'b0;
    end

    // Walk new strobes in priority order: issue, else park in the slot, else drop.
    for (int i = 2; i >= 0; i--) begin
      if (req_rise[i]) begin
        if (state_q == StIdle && !issue_v) begin
          issue_v     = 1'b1;
          issue_type  = req_e'(i[1:0]);
          issue_addr  = cpu_addr;
          issue_wdata = cpu_wdata;
        end else if (slot_free) begin
          pend_valid_d = 1'b1;
          pend_type_d  = req_e'(i[1:0]);
          pend_addr_d  = cpu_addr;
          pend_wdata_d = cpu_wdata;
          slot_free    = 1'b0;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    issue_mmio = (issue_addr >= MMIO_BASE);

    unique case (state_q)
      StIdle: begin
        if (issue_v) begin
          if (issue_type == ReqStore) begin
            if (issue_mmio) begin
              io_out_d = issue_wdata;
            end else begin
              state_d     = StWr;
              bram_we_d   = 1'b1;
              bram_addr_d = issue_addr;
              bram_din_d  = issue_wdata;
            end
          end else begin
            state_d    = StRdWait;
            cur_type_d = issue_type;
            cur_mmio_d = issue_mmio;
            if (!issue_mmio) bram_addr_d = issue_addr;
          end
        end
      end
      StRdWait: state_d = StRdData;
      StRdData: begin
        state_d = StIdle;
        if (cur_type_q == ReqLoad) begin
          load_data_d  = cur_mmio_q ? sync2_q : bram_dout;
          load_valid_d = 1'b1;
        end else begin
          instr_d       = cur_mmio_q ? '0 : bram_dout;
          instr_valid_d = 1'b1;
        end
      end
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      req_prev_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_type_q   <= ReqFetch;
      pend_addr_q   <= '0;
      pend_wdata_q  <= '0;
      cur_type_q    <= ReqFetch;
      cur_mmio_q    <= 1'b0;
      bram_addr_q   <= '0;
      bram_din_q    <= '0;
      bram_we_q     <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      load_data_q   <= '0;
      load_valid_q  <= 1'b0;
      io_out_q      <= '0;
      overrun_q     <= 1'b0;
      sync1_q       <= '0;
      sync2_q       <= '0;
    end else begin
      state_q       <= state_d;
      req_prev_q    <= {store_req, load_req, fetch_req};
      pend_valid_q  <= pend_valid_d;
      pend_type_q   <= pend_type_d;
      pend_addr_q   <= pend_addr_d;
      pend_wdata_q  <= pend_wdata_d;
      cur_type_q    <= cur_type_d;
      cur_mmio_q    <= cur_mmio_d;
      bram_addr_q   <= bram_addr_d;
      bram_din_q    <= bram_din_d;
      bram_we_q     <= bram_we_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      load_data_q   <= load_data_d;
      load_valid_q  <= load_valid_d;
      io_out_q      <= io_out_d;
      overrun_q     <= overrun_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = instr_valid_q;
  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;
  assign bram_addr   = bram_addr_q;
  assign bram_din    = bram_din_q;
  assign bram_we     = bram_we_q;
  assign io_out      = io_out_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: expected read results are queued with the cycle
// they must appear in and matched against pulses recorded by a passive monitor.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, load_req, store_req;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] instr_out, load_data, bram_din, bram_dout, io_in, io_out;
  logic        instr_valid, load_valid, busy, overrun, bram_we;
  logic [9:0]  bram_addr;

  logic        tb_wr;
  logic [9:0]  tb_wa;
  logic [15:0] tb_wd;
  logic [15:0] mem [1024];

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_i[$];
  exp_t        exp_l[$];
  exp_t        e;
  logic [15:0] i_obs_data [64];
  int          i_obs_cyc  [64];
  logic [15:0] l_obs_data [64];
  int          l_obs_cyc  [64];
  int          i_n = 0, l_n = 0, i_rd = 0, l_rd = 0;
  int          cyc = 0;
  int          n_checks = 0, n_pass = 0;

  cpu_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .load_req   (load_req),
    .store_req  (store_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .load_data  (load_data),
    .load_valid (load_valid),
    .busy       (busy),
    .overrun    (overrun),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_we    (bram_we),
    .bram_dout  (bram_dout),
    .io_in      (io_in),
    .io_out     (io_out)
  );

  always #5 clk = ~clk;

  // Synchronous read-first BRAM with a bench-side preload port.
  always @(posedge clk) begin
    if (tb_wr) mem[tb_wa] <= tb_wd;
    else if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (instr_valid && i_n < 64) begin
      i_obs_data[i_n] <= instr_out;
      i_obs_cyc[i_n]  <= cyc;
      i_n             <= i_n + 1;
    end
    if (load_valid && l_n < 64) begin
      l_obs_data[l_n] <= load_data;
      l_obs_cyc[l_n]  <= cyc;
      l_n             <= l_n + 1;
    end
  end

  task automatic test_reset();
    n_checks++;
    if ({instr_out, instr_valid, load_data, load_valid, busy, overrun, bram_addr, bram_din,
         bram_we, io_out} !== '0)
      $display("FAIL reset_initial: outputs not all zero (busy=%b we=%b ovr=%b io=%h)",
               busy, bram_we, overrun, io_out);
    else n_pass++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); store_req = 1'b1; cpu_addr = 10'h005; cpu_wdata = 16'hBEEF;
    @(posedge clk); #2;
    n_checks++;
    if (bram_we !== 1'b1) $display("FAIL reset_we_before: got %b want 1", bram_we);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bram_we !== 1'b0) $display("FAIL reset_we_async: got %b want 0", bram_we);
    else n_pass++;
    @(negedge clk); store_req = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({instr_out, instr_valid, load_data, load_valid, busy, overrun, bram_addr, bram_din,
         bram_we, io_out} !== '0)
      $display("FAIL reset_after: outputs not zero (busy=%b we=%b ovr=%b addr=%h)",
               busy, bram_we, overrun, bram_addr);
    else n_pass++;
    n_checks++;
    if (mem[10'h005] !== 16'h0BAD)
      $display("FAIL reset_aborted_write: mem[5]=%h want 0bad", mem[10'h005]);
    else n_pass++;
  endtask

  task automatic test_fetch();
    @(negedge clk); fetch_req = 1'b1; cpu_addr = 10'h010;
    exp_i.push_back('{16'h1234, cyc + 3});
    @(negedge clk); cpu_addr = 10'h3FF;
    n_checks++;
    if (busy !== 1'b1 || bram_addr !== 10'h010)
      $display("FAIL fetch_issue: busy=%b addr=%h want 1/010", busy, bram_addr);
    else n_pass++;
    @(negedge clk);
    @(negedge clk); fetch_req = 1'b0;
    repeat (6) @(negedge clk);
    while (exp_i.size() > 0) begin
      e = exp_i.pop_front();
      n_checks++;
      if (i_rd < i_n && i_obs_data[i_rd] === e.data && i_obs_cyc[i_rd] == e.cyc) n_pass++;
      else $display("FAIL fetch_data: got %h@%0d want %h@%0d",
                    i_obs_data[i_rd], i_obs_cyc[i_rd], e.data, e.cyc);
      i_rd++;
    end
    n_checks++;
    if (i_rd != i_n) $display("FAIL fetch_pulses: got %0d want %0d", i_n, i_rd);
    else n_pass++;
    n_checks++;
    if (instr_out !== 16'h1234 || busy !== 1'b0)
      $display("FAIL fetch_hold: instr=%h busy=%b want 1234/0", instr_out, busy);
    else n_pass++;
  endtask

  task automatic test_store_load();
    @(negedge clk); store_req = 1'b1; cpu_addr = 10'h020; cpu_wdata = 16'hA5A5;
    @(negedge clk); store_req = 1'b0; cpu_wdata = 16'h5A5A;
    n_checks++;
    if (bram_we !== 1'b1 || bram_addr !== 10'h020 || bram_din !== 16'hA5A5 || busy !== 1'b1)
      $display("FAIL store_cycle: we=%b addr=%h din=%h busy=%b want 1/020/a5a5/1",
               bram_we, bram_addr, bram_din, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bram_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL store_end: we=%b busy=%b want 0/0", bram_we, busy);
    else n_pass++;
    load_req = 1'b1; cpu_addr = 10'h020;
    exp_l.push_back('{16'hA5A5, cyc + 3});
    @(negedge clk); load_req = 1'b0;
    repeat (6) @(negedge clk);
    while (exp_l.size() > 0) begin
      e = exp_l.pop_front();
      n_checks++;
      if (l_rd < l_n && l_obs_data[l_rd] === e.data && l_obs_cyc[l_rd] == e.cyc) n_pass++;
      else $display("FAIL load_data: got %h@%0d want %h@%0d",
                    l_obs_data[l_rd], l_obs_cyc[l_rd], e.data, e.cyc);
      l_rd++;
    end
    n_checks++;
    if (l_rd != l_n) $display("FAIL load_pulses: got %0d want %0d", l_n, l_rd);
    else n_pass++;
  endtask

  task automatic test_same_edge();
    @(negedge clk); store_req = 1'b1; fetch_req = 1'b1; cpu_addr = 10'h030;
    cpu_wdata = 16'h4321;
    exp_i.push_back('{16'h4321, cyc + 5});
    @(negedge clk); store_req = 1'b0; fetch_req = 1'b0;
    n_checks++;
    if (bram_we !== 1'b1 || bram_addr !== 10'h030 || bram_din !== 16'h4321)
      $display("FAIL same_edge_store_first: we=%b addr=%h din=%h", bram_we, bram_addr, bram_din);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || bram_we !== 1'b0)
      $display("FAIL same_edge_pending_issue: busy=%b we=%b want 1/0", busy, bram_we);
    else n_pass++;
    repeat (5) @(negedge clk);
    while (exp_i.size() > 0) begin
      e = exp_i.pop_front();
      n_checks++;
      if (i_rd < i_n && i_obs_data[i_rd] === e.data && i_obs_cyc[i_rd] == e.cyc) n_pass++;
      else $display("FAIL same_edge_fetch: got %h@%0d want %h@%0d",
                    i_obs_data[i_rd], i_obs_cyc[i_rd], e.data, e.cyc);
      i_rd++;
    end
    n_checks++;
    if (i_rd != i_n) $display("FAIL same_edge_pulses: got %0d want %0d", i_n, i_rd);
    else n_pass++;
  endtask

  task automatic test_mmio();
    @(negedge clk); store_req = 1'b1; cpu_addr = 10'h3F0; cpu_wdata = 16'h00FF;
    @(negedge clk); store_req = 1'b0;
    n_checks++;
    if (io_out !== 16'h00FF || bram_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL mmio_store: io=%h we=%b busy=%b want 00ff/0/0", io_out, bram_we, busy);
    else n_pass++;
    io_in = 16'h0003;
    repeat (3) @(negedge clk);
    load_req = 1'b1; cpu_addr = 10'h3F1;
    exp_l.push_back('{16'h0003, cyc + 3});
    @(negedge clk); load_req = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bram_addr !== 10'h030)
      $display("FAIL mmio_load_issue: busy=%b addr=%h want 1/030", busy, bram_addr);
    else n_pass++;
    repeat (4) @(negedge clk);
    fetch_req = 1'b1; cpu_addr = 10'h3F2;
    exp_i.push_back('{16'h0000, cyc + 3});
    @(negedge clk); fetch_req = 1'b0;
    repeat (5) @(negedge clk);
    while (exp_l.size() > 0) begin
      e = exp_l.pop_front();
      n_checks++;
      if (l_rd < l_n && l_obs_data[l_rd] === e.data && l_obs_cyc[l_rd] == e.cyc) n_pass++;
      else $display("FAIL mmio_load: got %h@%0d want %h@%0d",
                    l_obs_data[l_rd], l_obs_cyc[l_rd], e.data, e.cyc);
      l_rd++;
    end
    while (exp_i.size() > 0) begin
      e = exp_i.pop_front();
      n_checks++;
      if (i_rd < i_n && i_obs_data[i_rd] === e.data && i_obs_cyc[i_rd] == e.cyc) n_pass++;
      else $display("FAIL mmio_fetch: got %h@%0d want %h@%0d",
                    i_obs_data[i_rd], i_obs_cyc[i_rd], e.data, e.cyc);
      i_rd++;
    end
    n_checks++;
    if (bram_addr !== 10'h030 || i_rd != i_n || l_rd != l_n)
      $display("FAIL mmio_no_bram: addr=%h pulses i=%0d/%0d l=%0d/%0d want 030 and equal",
               bram_addr, i_n, i_rd, l_n, l_rd);
    else n_pass++;
  endtask

  task automatic test_overrun();
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL overrun_initial: got %b want 0", overrun);
    else n_pass++;
    @(negedge clk); fetch_req = 1'b1; cpu_addr = 10'h040;
    exp_i.push_back('{16'h1111, cyc + 3});
    exp_l.push_back('{16'h2222, cyc + 6});
    @(negedge clk); fetch_req = 1'b0; load_req = 1'b1; cpu_addr = 10'h041;
    @(negedge clk); fetch_req = 1'b1; cpu_addr = 10'h042;
    @(negedge clk); fetch_req = 1'b0; load_req = 1'b0;
    n_checks++;
    if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun);
    else n_pass++;
    repeat (8) @(negedge clk);
    while (exp_i.size() > 0) begin
      e = exp_i.pop_front();
      n_checks++;
      if (i_rd < i_n && i_obs_data[i_rd] === e.data && i_obs_cyc[i_rd] == e.cyc) n_pass++;
      else $display("FAIL overrun_fetch: got %h@%0d want %h@%0d",
                    i_obs_data[i_rd], i_obs_cyc[i_rd], e.data, e.cyc);
      i_rd++;
    end
    while (exp_l.size() > 0) begin
      e = exp_l.pop_front();
      n_checks++;
      if (l_rd < l_n && l_obs_data[l_rd] === e.data && l_obs_cyc[l_rd] == e.cyc) n_pass++;
      else $display("FAIL overrun_load: got %h@%0d want %h@%0d",
                    l_obs_data[l_rd], l_obs_cyc[l_rd], e.data, e.cyc);
      l_rd++;
    end
    n_checks++;
    if (i_rd != i_n || l_rd != l_n)
      $display("FAIL overrun_dropped: pulses i=%0d/%0d l=%0d/%0d want equal",
               i_n, i_rd, l_n, l_rd);
    else n_pass++;
    n_checks++;
    if (overrun !== 1'b1 || busy !== 1'b0)
      $display("FAIL overrun_sticky: ovr=%b busy=%b want 1/0", overrun, busy);
    else n_pass++;
  endtask

  initial begin
    logic [9:0]  pa [6];
    logic [15:0] pd [6];
    pa = '{10'h005, 10'h010, 10'h020, 10'h040, 10'h041, 10'h042};
    pd = '{16'h0BAD, 16'h1234, 16'h0000, 16'h1111, 16'h2222, 16'h3333};
    reset = 1'b0;
    fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; io_in = '0;
    tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); tb_wr = 1'b1; tb_wa = pa[i]; tb_wd = pd[i];
    end
    @(negedge clk); tb_wr = 1'b0;
    test_reset();
    test_fetch();
    test_store_load();
    test_same_edge();
    test_mmio();
    test_overrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
